// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU-side memory bus router.
// The region numbers fix where BRAM and the peripheral controller sit in the address map.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned REGION_BRAM = 32'd0;
  localparam int unsigned REGION_IO   = 32'd1;
  localparam int unsigned TIMEOUT_DEF = 32'd15;
  localparam int unsigned ERR_CNT_W   = 32'd16;
  localparam int unsigned TMO_CNT_W   = 32'd8;

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational region decode: splits a CPU address into region index, mapped flag,
// one-hot slave select and the slave-local offset.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int REGION_BITS = 4,
  parameter int N_SLV       = 4
) (
  input  logic [ADDR_W-1:0]             addr,
  output logic [REGION_BITS-1:0]        idx,
  output logic                          mapped,
  output logic [N_SLV-1:0]              sel,
  output logic [ADDR_W-REGION_BITS-1:0] offset
);

  // Region index from the top bits; the extra compare bit allows N_SLV == 2^REGION_BITS.
  always_comb begin
    idx    = addr[ADDR_W-1 -: REGION_BITS];
    offset = addr[ADDR_W-REGION_BITS-1:0];
    mapped = ({1'b0, idx} < (REGION_BITS+1)'(N_SLV));
    sel    = '0;
    for (int i = 0; i < N_SLV; i++) begin
      sel[i] = (idx == REGION_BITS'(i));
    end
  end

endmodule

// File: rtl/mem_bus_router.sv
// Routes one CPU load/store at a time to one of N_SLV slave regions with a req/ack
// handshake, reporting unmapped addresses and slave timeouts as bus errors.
module mem_bus_router
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int N_SLV       = 4,
  parameter int REGION_BITS = 4,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic                          cpu_ready,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_err,
  output logic                          cpu_busy,
  output logic [N_SLV-1:0]              s_req,
  output logic                          s_we,
  output logic [ADDR_W-REGION_BITS-1:0] s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  input  logic [N_SLV*DATA_W-1:0]       s_rdata,
  input  logic [N_SLV-1:0]              s_ack,
  output logic [ERR_CNT_W-1:0]          err_count
);

  localparam int OFF_W = ADDR_W - REGION_BITS;
  localparam logic [TMO_CNT_W-1:0] TIMEOUT_C = TMO_CNT_W'(TIMEOUT);

  state_e                 state_r, state_s;
  logic [TMO_CNT_W-1:0]   cnt_r, cnt_s;
  logic [REGION_BITS-1:0] idx_s, idx_r;
  logic                   mapped_s;
  logic [N_SLV-1:0]       sel_s, sel_r;
  logic [OFF_W-1:0]       off_s;
  logic                   ack_hit_s;
  logic [DATA_W-1:0]      slv_rdata_s, resp_data_s;
  logic                   resp_err_s;

  mem_bus_decode #(
    .ADDR_W      (ADDR_W),
    .REGION_BITS (REGION_BITS),
    .N_SLV       (N_SLV)
  ) u_decode (
    .addr   (cpu_addr),
    .idx    (idx_s),
    .mapped (mapped_s),
    .sel    (sel_s),
    .offset (off_s)
  );

  // Read-data mux for the latched region.
  always_comb begin
    slv_rdata_s = '0;
    for (int i = 0; i < N_SLV; i++) begin
      slv_rdata_s = (idx_r == REGION_BITS'(i)) ? s_rdata[i*DATA_W +: DATA_W] : slv_rdata_s;
    end
  end

  // Next state, timeout counter and the response to present on entry to RESP.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    resp_data_s = '0;
    resp_err_s  = 1'b0;
    ack_hit_s   = |(s_ack & sel_r);
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          if (mapped_s) begin
            state_s = REQ;
          end else begin
            state_s    = RESP;
            resp_err_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        // An ack in the expiry cycle still counts as success.
        if (ack_hit_s) begin
          state_s     = RESP;
          resp_data_s = s_we ? '0 : slv_rdata_s;
        end else begin
          cnt_s = cnt_r + 8'd1;
          if (cnt_s == TIMEOUT_C) begin
            state_s    = RESP;
            resp_err_s = 1'b1;
          end else begin
            state_s = REQ;
          end
        end
      end
      RESP: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, request latches and registered CPU/slave outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      idx_r     <= '0;
      sel_r     <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      cpu_err   <= 1'b0;
      cpu_busy  <= 1'b0;
      s_req     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      err_count <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      cpu_busy  <= (state_s != IDLE);
      cpu_ready <= (state_s == RESP);
      cpu_rdata <= resp_data_s;
      cpu_err   <= resp_err_s;
      if (state_r == IDLE && cpu_req) begin
        s_we    <= cpu_we;
        s_addr  <= off_s;
        s_wdata <= cpu_wdata;
        idx_r   <= idx_s;
        sel_r   <= sel_s;
      end
      s_req <= (state_s == REQ) ? ((state_r == REQ) ? sel_r : sel_s) : '0;
      if (resp_err_s && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
